// File: rtl/fib_lfsr_axi_slave.sv
// rtl/fib_lfsr_axi_slave.sv - AXI4-Lite slave around a 32-bit Fibonacci LFSR with seed/tap registers.
// Optional all-zero lockup recovery is built when FIB_LFSR_LOCKUP_GUARD_EN is defined.
module fib_lfsr_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     lfsr_state,
    output logic                              lfsr_step
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t        w_state;
    r_state_t        r_state;
    logic            bvalid;
    logic            rvalid;
    logic [DW-1:0]   rdata;
    logic [DW-1:0]   rd_mux;
    logic            run;
    logic            lockup;
    logic [DW-1:0]   seed;
    logic [DW-1:0]   taps;
    logic [DW-1:0]   state;
    logic            step;
    logic            aw_hs;
    logic            ar_hs;
    logic            load_req;
    logic            fb;
    logic [1:0]      wsel;
    logic [1:0]      rsel;
    logic            unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wsel = S_AXI_AWADDR[3:2];
    assign rsel = S_AXI_ARADDR[3:2];

    // Ready is a single-cycle acknowledge of the IDLE-state handshake; held low while in reset.
    assign aw_hs = !S_AXI_ARESET && (w_state == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID;
    assign ar_hs = !S_AXI_ARESET && (r_state == R_IDLE) && S_AXI_ARVALID;

    assign S_AXI_AWREADY = aw_hs;
    assign S_AXI_WREADY  = aw_hs;
    assign S_AXI_ARREADY = ar_hs;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata;
    assign lfsr_state    = state;
    assign lfsr_step     = step;

    assign load_req = aw_hs && (wsel == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
    assign fb       = ^(state & taps);

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                  input logic [DW-1:0] new_val,
                                                  input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rd_mux = '0;
        case (rsel)
            2'd0: rd_mux = {{(DW-3){1'b0}}, lockup, 1'b0, run};
            2'd1: rd_mux = seed;
            2'd2: rd_mux = taps;
            default: rd_mux = state;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            run     <= 1'b0;
            seed    <= 32'h0000_0001;
            taps    <= 32'h8020_0003;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        case (wsel)
                            2'd0: if (S_AXI_WSTRB[0]) run <= S_AXI_WDATA[0];
                            2'd1: seed <= merge_bytes(seed, S_AXI_WDATA, S_AXI_WSTRB);
                            2'd2: taps <= merge_bytes(taps, S_AXI_WDATA, S_AXI_WSTRB);
                            default: ;
                        endcase
                        w_state <= W_RESP;
                        bvalid  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        w_state <= W_IDLE;
                        bvalid  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rdata   <= rd_mux;
                        rvalid  <= 1'b1;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        rvalid  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

`ifndef FIB_LFSR_LOCKUP_GUARD_EN
    assign lockup = 1'b0;
`endif

    // Load uses the seed held before this write, so a same-cycle SEED write cannot race it.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state  <= 32'h0000_0001;
            step   <= 1'b0;
`ifdef FIB_LFSR_LOCKUP_GUARD_EN
            lockup <= 1'b0;
`endif
        end else begin
            step <= 1'b0;
            if (load_req) begin
                state  <= seed;
`ifdef FIB_LFSR_LOCKUP_GUARD_EN
                lockup <= 1'b0;
`endif
            end else if (run) begin
                step <= 1'b1;
`ifdef FIB_LFSR_LOCKUP_GUARD_EN
                if (state == '0) begin
                    state  <= 32'h0000_0001;
                    lockup <= 1'b1;
                end else
`endif
                state <= {state[DW-2:0], fb};
            end
        end
    end

endmodule
